// File: rtl/data_memory_dumper_if.sv
// Bus bundle between data_memory_dumper and its data-memory read port / UART transmitter.
// master = dumper side, slave = memory + UART side.
interface data_memory_dumper_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int RAM_WIDTH  = 16
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_write;
    logic [RAM_WIDTH-1:0]  mem_rdata;
    logic                  tx_start;
    logic [7:0]            tx_data;
    logic                  tx_done;

    modport master (
        output mem_addr, mem_write, tx_start, tx_data,
        input  mem_rdata, tx_done
    );

    modport slave (
        input  mem_addr, mem_write, tx_start, tx_data,
        output mem_rdata, tx_done
    );
endinterface

// File: rtl/data_memory_dumper.sv
// Walks data memory 0..DUMP_DEPTH-1 and sends each word over UART, high byte first.
// Optional trailing XOR checksum byte when DUMP_CHECKSUM_EN is defined.
module data_memory_dumper #(
    parameter int RAM_WIDTH  = 16,
    parameter int ADDR_WIDTH = 11,
    parameter int DUMP_DEPTH = 2048
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    data_memory_dumper_if.master        bus,
    output logic                        busy,
    output logic                        done
);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DUMP_DEPTH - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SET_ADDR,
        S_LATCH,
        S_SEND_HI,
        S_WAIT_HI,
        S_SEND_LO,
        S_WAIT_LO,
`ifdef DUMP_CHECKSUM_EN
        S_CK_SEND,
        S_CK_WAIT,
`endif
        S_FINISH
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [RAM_WIDTH-1:0]  r_word;
    logic [7:0]            r_tx_data;
    logic                  w_tx_start;
    logic                  w_last;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]            r_cksum;
`endif

    assign w_last = (r_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_tx_start = 1'b0;
        case (r_state)
            S_IDLE:     if (start) w_next = S_SET_ADDR;
            S_SET_ADDR: w_next = S_LATCH;
            S_LATCH:    w_next = S_SEND_HI;
            S_SEND_HI: begin
                w_tx_start = 1'b1;
                w_next     = S_WAIT_HI;
            end
            S_WAIT_HI:  if (bus.tx_done) w_next = S_SEND_LO;
            S_SEND_LO: begin
                w_tx_start = 1'b1;
                w_next     = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (bus.tx_done) begin
`ifdef DUMP_CHECKSUM_EN
                    w_next = w_last ? S_CK_SEND : S_SET_ADDR;
`else
                    w_next = w_last ? S_FINISH : S_SET_ADDR;
`endif
                end
            end
`ifdef DUMP_CHECKSUM_EN
            S_CK_SEND: begin
                w_tx_start = 1'b1;
                w_next     = S_CK_WAIT;
            end
            S_CK_WAIT:  if (bus.tx_done) w_next = S_FINISH;
`endif
            S_FINISH:   w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // tx_data is loaded one edge ahead of each SEND state so it is stable through the wait
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_word    <= '0;
            r_tx_data <= '0;
`ifdef DUMP_CHECKSUM_EN
            r_cksum   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx   <= '0;
`ifdef DUMP_CHECKSUM_EN
                        r_cksum <= '0;
`endif
                    end
                end
                S_LATCH: begin
                    r_word    <= bus.mem_rdata;
                    r_tx_data <= bus.mem_rdata[15:8];
                end
                S_WAIT_HI: if (bus.tx_done) r_tx_data <= r_word[7:0];
                S_WAIT_LO: begin
                    if (bus.tx_done) begin
                        if (!w_last) r_idx <= r_idx + 1'b1;
`ifdef DUMP_CHECKSUM_EN
                        else         r_tx_data <= r_cksum;
`endif
                    end
                end
`ifdef DUMP_CHECKSUM_EN
                S_SEND_HI, S_SEND_LO: r_cksum <= r_cksum ^ r_tx_data;
`endif
                default: ;
            endcase
        end
    end

    assign bus.mem_addr  = r_idx;
    assign bus.mem_write = 1'b0;
    assign bus.tx_start  = w_tx_start;
    assign bus.tx_data   = r_tx_data;
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_FINISH);
endmodule

// File: tb/tb_data_memory_dumper.sv
// Scoreboard bench for data_memory_dumper: a 2-word instance for handshake cases
// and a full 2048-word instance for the address-range sweep.
module tb_data_memory_dumper;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic startA, startB;
    logic busyA, doneA, busyB, doneB;

    int checks   = 0;
    int failures = 0;

    data_memory_dumper_if #(.ADDR_WIDTH(11), .RAM_WIDTH(16)) busA ();
    data_memory_dumper_if #(.ADDR_WIDTH(11), .RAM_WIDTH(16)) busB ();

    data_memory_dumper #(.RAM_WIDTH(16), .ADDR_WIDTH(11), .DUMP_DEPTH(2)) dutA (
        .clk(clk), .rst_n(rst_n), .start(startA), .bus(busA), .busy(busyA), .done(doneA));
    data_memory_dumper #(.RAM_WIDTH(16), .ADDR_WIDTH(11), .DUMP_DEPTH(2048)) dutB (
        .clk(clk), .rst_n(rst_n), .start(startB), .bus(busB), .busy(busyB), .done(doneB));

    logic [15:0] memA [0:2047];
    logic [15:0] memB [0:2047];
    always @(posedge clk) busA.mem_rdata <= memA[busA.mem_addr];
    always @(posedge clk) busB.mem_rdata <= memB[busB.mem_addr];

    logic [7:0] qA[$];
    logic [7:0] qB[$];
    int  delayA   = 5;
    int  bytesA   = 0, bytesB = 0;
    int  doneCntA = 0, doneCntB = 0;
    logic memwr_bad = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // UART models: acknowledge each byte a fixed number of cycles after tx_start
    initial begin : uartA
        int cnt;
        logic pend;
        logic [7:0] hold;
        pend = 1'b0; cnt = 0; hold = '0;
        busA.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            busA.tx_done = 1'b0;
            if (!rst_n) pend = 1'b0;
            else if (busA.tx_start) begin
                check("A_one_start_per_byte", {31'd0, pend}, 32'd0);
                pend = 1'b1; cnt = delayA; hold = busA.tx_data;
            end else if (pend) begin
                check("A_tx_data_stable", {24'd0, busA.tx_data}, {24'd0, hold});
                if (cnt <= 1) begin busA.tx_done = 1'b1; pend = 1'b0; end
                else cnt--;
            end
        end
    end

    initial begin : uartB
        logic pend;
        pend = 1'b0;
        busB.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            busB.tx_done = 1'b0;
            if (!rst_n) pend = 1'b0;
            else if (busB.tx_start) pend = 1'b1;
            else if (pend) begin busB.tx_done = 1'b1; pend = 1'b0; end
        end
    end

    // Scoreboard monitors
    initial begin : monA
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (busA.mem_write !== 1'b0) memwr_bad = 1'b1;
            if (rst_n && busA.tx_start) begin
                bytesA++;
                check("A_byte_expected", {31'd0, qA.size() != 0}, 32'd1);
                if (qA.size() != 0) begin
                    e = qA.pop_front();
                    check("A_byte", {24'd0, busA.tx_data}, {24'd0, e});
                end
            end
            if (rst_n && doneA) begin
                doneCntA++;
                check("A_done_after_last_byte", qA.size(), 0);
            end
        end
    end

    initial begin : monB
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (busB.mem_write !== 1'b0) memwr_bad = 1'b1;
            if (rst_n && busB.tx_start) begin
                bytesB++;
                if (qB.size() == 0) check("B_byte_expected", 32'd0, 32'd1);
                else begin
                    e = qB.pop_front();
                    check("B_byte", {24'd0, busB.tx_data}, {24'd0, e});
                end
            end
            if (rst_n && doneB) begin
                doneCntB++;
                check("B_done_after_last_byte", qB.size(), 0);
            end
        end
    end

    task automatic push_A();
        qA.push_back(8'h12); qA.push_back(8'h34);
        qA.push_back(8'hAB); qA.push_back(8'hCD);
`ifdef DUMP_CHECKSUM_EN
        qA.push_back(8'h40);
`endif
    endtask

    task automatic pulse_A();
        @(negedge clk); startA = 1'b1;
        @(negedge clk); startA = 1'b0;
    endtask

    task automatic wait_done_A(input int budget, input string name);
        int n; logic got;
        n = 0; got = 1'b0;
        while (n < budget && !got) begin
            @(negedge clk);
            if (doneA) got = 1'b1;
            n++;
        end
        check(name, {31'd0, got}, 32'd1);
        @(negedge clk);
    endtask

    int bytes_per_dump;

    initial begin : main
        int n; int starts; logic [7:0] ck;
`ifdef DUMP_CHECKSUM_EN
        bytes_per_dump = 5;
`else
        bytes_per_dump = 4;
`endif
        rst_n = 1'b0; startA = 1'b0; startB = 1'b0;
        for (int a = 0; a < 2048; a++) begin
            memA[a] = '0;
            memB[a] = 16'(a);
        end
        memA[0] = 16'h1234;
        memA[1] = 16'hABCD;

        #1;
        check("rst_mem_addr", {21'd0, busA.mem_addr}, 32'd0);
        check("rst_tx_start", {31'd0, busA.tx_start}, 32'd0);
        check("rst_tx_data",  {24'd0, busA.tx_data}, 32'd0);
        check("rst_busy",     {31'd0, busyA}, 32'd0);
        check("rst_done",     {31'd0, doneA}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // T1: basic 2-word dump with latency check
        delayA = 5;
        push_A();
        pulse_A();
        check("T1_busy_after_start", {31'd0, busyA}, 32'd1);
        @(negedge clk);
        check("T1_no_early_tx", {31'd0, busA.tx_start}, 32'd0);
        @(negedge clk);
        check("T1_tx_latency", {31'd0, busA.tx_start}, 32'd1);
        wait_done_A(200, "T1_done_seen");
        check("T1_done_once", doneCntA, 1);
        check("T1_busy_low", {31'd0, busyA}, 32'd0);
        check("T1_done_low", {31'd0, doneA}, 32'd0);
        check("T1_byte_count", bytesA, bytes_per_dump);

        // T3: long tx_done wait
        delayA = 40;
        push_A();
        pulse_A();
        wait_done_A(2000, "T3_done_seen");
        check("T3_done_count", doneCntA, 2);
        check("T3_byte_count", bytesA, 2 * bytes_per_dump);
        check("T3_mem_write_zero", {31'd0, memwr_bad}, 32'd0);

        // T4: start re-pulsed during WAIT_HI is ignored and not queued
        delayA = 5;
        push_A();
        pulse_A();
        n = 0;
        while (n < 50 && !busA.tx_start) begin @(negedge clk); n++; end
        check("T4_first_tx_seen", {31'd0, busA.tx_start}, 32'd1);
        @(negedge clk); startA = 1'b1;
        @(negedge clk); startA = 1'b0;
        wait_done_A(200, "T4_done_seen");
        check("T4_done_count", doneCntA, 3);
        for (int i = 0; i < 5; i++) begin
            check("T4_no_queued_start", {31'd0, busyA}, 32'd0);
            @(negedge clk);
        end
        check("T4_byte_count", bytesA, 3 * bytes_per_dump);

        // T5: reset during WAIT_LO of word 1, then restart from address 0
        push_A();
        pulse_A();
        starts = 0; n = 0;
        while (n < 200 && starts < 4) begin
            @(negedge clk);
            if (busA.tx_start) starts++;
            n++;
        end
        check("T5_reached_word1_lo", starts, 4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("T5_rst_mem_addr", {21'd0, busA.mem_addr}, 32'd0);
        check("T5_rst_tx_start", {31'd0, busA.tx_start}, 32'd0);
        check("T5_rst_tx_data",  {24'd0, busA.tx_data}, 32'd0);
        check("T5_rst_busy",     {31'd0, busyA}, 32'd0);
        check("T5_rst_done",     {31'd0, doneA}, 32'd0);
        qA.delete();
        @(negedge clk);
        rst_n = 1'b1;
        push_A();
        pulse_A();
        wait_done_A(200, "T5_done_seen");
        check("T5_done_count", doneCntA, 4);

        // T6: full-depth sweep on the 2048-word instance
        ck = '0;
        for (int a = 0; a < 2048; a++) begin
            logic [15:0] w;
            w = 16'(a);
            qB.push_back(w[15:8]);
            qB.push_back(w[7:0]);
            ck = ck ^ w[15:8] ^ w[7:0];
        end
`ifdef DUMP_CHECKSUM_EN
        qB.push_back(ck);
`endif
        @(negedge clk); startB = 1'b1;
        @(negedge clk); startB = 1'b0;
        n = 0;
        while (n < 30000 && !doneB) begin @(negedge clk); n++; end
        check("T6_done_seen", {31'd0, doneB}, 32'd1);
        @(negedge clk);
        check("T6_last_addr", {21'd0, busB.mem_addr}, 32'h7FF);
        check("T6_byte_count", bytesB, bytes_per_dump == 5 ? 4097 : 4096);
        check("T6_done_once", doneCntB, 1);
        check("T6_busy_low", {31'd0, busyB}, 32'd0);
        check("T6_mem_write_zero", {31'd0, memwr_bad}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
